// File: rtl/pacman_gfx_pkg.sv
// rtl/pacman_gfx_pkg.sv - state encoding and default geometry for the tile-sprite renderer
package pacman_gfx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERASE = 3'd1,
    LOAD  = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } blit_state_t;

  localparam int DEF_SPR_W     = 5;
  localparam int DEF_SPR_H     = 5;
  localparam int DEF_X_W       = 8;
  localparam int DEF_Y_W       = 7;
  localparam int DEF_TX_W      = 5;
  localparam int DEF_TY_W      = 4;
  localparam int DEF_COL_W     = 3;
  localparam int DEF_BG_COLOUR = 0;

  // Counter width that stays legal for a 1-pixel dimension.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// rtl/sprite_pixel_counter.sv - row-major (col,row) scan over an SPR_W x SPR_H sprite
module sprite_pixel_counter
  import pacman_gfx_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H,
  localparam int CW = cnt_width(SPR_W),
  localparam int RW = cnt_width(SPR_H)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end;

  assign col_end = (col_q == CW'(SPR_W - 1));
  assign last    = col_end && (row_q == RW'(SPR_H - 1));
  assign col     = col_q;
  assign row     = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    // Wrapping on last leaves the counter at (0,0) for whichever state follows.
    if (clear || (enable && last)) begin
      col_d = '0;
      row_d = '0;
    end else if (enable) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - erase/load/draw tile sprite renderer; SPRITE_TRANSPARENT_EN skips 0-bit pixels in DRAW
module sprite_blitter
  import pacman_gfx_pkg::*;
#(
  parameter int SPR_W     = DEF_SPR_W,
  parameter int SPR_H     = DEF_SPR_H,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int TX_W      = DEF_TX_W,
  parameter int TY_W      = DEF_TY_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [TX_W-1:0]        tile_x,
  input  logic [TY_W-1:0]        tile_y,
  input  logic [SPR_W*SPR_H-1:0] shape,
  input  logic [COL_W-1:0]       colour,
  output logic                   busy,
  output logic                   done,
  output logic                   plot,
  output logic [X_W-1:0]         x_out,
  output logic [Y_W-1:0]         y_out,
  output logic [COL_W-1:0]       col_out
);

  localparam int N  = SPR_W * SPR_H;
  localparam int CW = cnt_width(SPR_W);
  localparam int RW = cnt_width(SPR_H);
  localparam int IW = cnt_width(N);

  blit_state_t      state_q, state_d;
  logic [X_W-1:0]   base_x_q;
  logic [Y_W-1:0]   base_y_q;
  logic [N-1:0]     shape_q;
  logic [COL_W-1:0] colour_q;
  logic             old_valid_q;
  logic             busy_q, done_q, plot_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [COL_W-1:0] col_q;

  logic [CW-1:0]    pix_col;
  logic [RW-1:0]    pix_row;
  logic             pix_last, cnt_en;
  logic [IW-1:0]    bit_idx;
  logic             pix_bit;
  logic [X_W-1:0]   base_x_d, pix_x;
  logic [Y_W-1:0]   base_y_d, pix_y;
  logic [COL_W-1:0] draw_col;

  assign cnt_en = (state_q == ERASE) || (state_q == DRAW);

  sprite_pixel_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!cnt_en),
    .enable  (cnt_en),
    .col     (pix_col),
    .row     (pix_row),
    .last    (pix_last)
  );

  // Base products are truncated to screen width on purpose: sprites wrap, never clip.
  assign base_x_d = X_W'(32'(tile_x) * SPR_W);
  assign base_y_d = Y_W'(32'(tile_y) * SPR_H);

  assign pix_x    = base_x_q + X_W'(pix_col);
  assign pix_y    = base_y_q + Y_W'(pix_row);
  assign bit_idx  = IW'(N - 1 - (int'(pix_row) * SPR_W + int'(pix_col)));
  assign pix_bit  = shape_q[bit_idx];
  assign draw_col = pix_bit ? colour_q : COL_W'(BG_COLOUR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = old_valid_q ? ERASE : LOAD;
      ERASE:   if (pix_last) state_d = LOAD;
      LOAD:    state_d = DRAW;
      DRAW:    if (pix_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_x_q    <= '0;
      base_y_q    <= '0;
      shape_q     <= '0;
      colour_q    <= '0;
      old_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      col_q       <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == DONE);

      if (state_q == LOAD) begin
        base_x_q    <= base_x_d;
        base_y_q    <= base_y_d;
        shape_q     <= shape;
        colour_q    <= colour;
        old_valid_q <= 1'b1;
      end

      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= '0;
      if (state_q == ERASE) begin
        plot_q <= 1'b1;
        x_q    <= pix_x;
        y_q    <= pix_y;
        col_q  <= COL_W'(BG_COLOUR);
      end else if (state_q == DRAW) begin
        x_q   <= pix_x;
        y_q   <= pix_y;
        col_q <= draw_col;
`ifdef SPRITE_TRANSPARENT_EN
        plot_q <= pix_bit;
`else
        plot_q <= 1'b1;
`endif
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign plot    = plot_q;
  assign x_out   = x_q;
  assign y_out   = y_q;
  assign col_out = col_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter
module tb_sprite_blitter;

  logic        clk;
  logic        reset_n;

  logic        start;
  logic [4:0]  tile_x;
  logic [3:0]  tile_y;
  logic [24:0] shape;
  logic [2:0]  colour;
  logic        busy, done, plot;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  col_out;

  logic        start8, busy8, done8, plot8;
  logic [4:0]  tile_x8;
  logic [3:0]  tile_y8;
  logic [47:0] shape8;
  logic [2:0]  colour8, col8;
  logic [7:0]  x8;
  logic [6:0]  y8;

  logic        start9, busy9, done9, plot9;
  logic [4:0]  tile_x9;
  logic [3:0]  tile_y9;
  logic [53:0] shape9;
  logic [2:0]  colour9, col9;
  logic [7:0]  x9;
  logic [6:0]  y9;

  int checks = 0;
  int errors = 0;
  int px_x[$];
  int px_y[$];
  int px_c[$];
  int done_cnt = 0;

  sprite_blitter u_dut (
    .clock(clk), .reset_n(reset_n), .start(start), .tile_x(tile_x), .tile_y(tile_y),
    .shape(shape), .colour(colour), .busy(busy), .done(done), .plot(plot),
    .x_out(x_out), .y_out(y_out), .col_out(col_out)
  );

  sprite_blitter #(.SPR_W(8), .SPR_H(6)) u_w8 (
    .clock(clk), .reset_n(reset_n), .start(start8), .tile_x(tile_x8), .tile_y(tile_y8),
    .shape(shape8), .colour(colour8), .busy(busy8), .done(done8), .plot(plot8),
    .x_out(x8), .y_out(y8), .col_out(col8)
  );

  sprite_blitter #(.SPR_W(9), .SPR_H(6)) u_w9 (
    .clock(clk), .reset_n(reset_n), .start(start9), .tile_x(tile_x9), .tile_y(tile_y9),
    .shape(shape9), .colour(colour9), .busy(busy9), .done(done9), .plot(plot9),
    .x_out(x9), .y_out(y9), .col_out(col9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (plot) begin
      px_x.push_back(int'(x_out));
      px_y.push_back(int'(y_out));
      px_c.push_back(int'(col_out));
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic go5(input logic [4:0] tx, input logic [3:0] ty, input logic [24:0] shp,
                     input logic [2:0] c, output int cyc);
    px_x.delete(); px_y.delete(); px_c.delete();
    done_cnt = 0;
    tile_x = tx; tile_y = ty; shape = shp; colour = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); cyc++; #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, plot} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, plot});
    end
    checks++;
    if ({x_out, y_out, col_out} !== 18'd0) begin
      errors++; $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d want 0", x_out, y_out, col_out);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, plot, busy8, busy9} !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset: got %b want 0000", {busy, plot, busy8, busy9});
    end
  endtask

  task automatic test_first_draw();
    int cyc;
    go5(5'd2, 4'd3, 25'h1FFFFFF, 3'b110, cyc);
    checks++;
    if (cyc !== 27) begin errors++; $display("FAIL first_latency: got %0d want 27", cyc); end
    checks++;
    if (px_x.size() !== 25) begin errors++; $display("FAIL first_count: got %0d want 25", px_x.size()); end
    for (int k = 0; k < 25 && k < px_x.size(); k++) begin
      checks++;
      if (px_x[k] !== 10 + k % 5 || px_y[k] !== 15 + k / 5 || px_c[k] !== 6) begin
        errors++;
        $display("FAIL first_pixel[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,6)",
                 k, px_x[k], px_y[k], px_c[k], 10 + k % 5, 15 + k / 5);
      end
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL first_done: got done_cnt=%0d busy=%b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_redraw_erase();
    int cyc;
    int ex, ey, ec;
    go5(5'd0, 4'd0, 25'h1FFFFFF, 3'b110, cyc);
    checks++;
    if (cyc !== 52) begin errors++; $display("FAIL erase_latency: got %0d want 52", cyc); end
    checks++;
    if (px_x.size() !== 50) begin errors++; $display("FAIL erase_count: got %0d want 50", px_x.size()); end
    for (int k = 0; k < 50 && k < px_x.size(); k++) begin
      if (k < 25) begin ex = 10 + k % 5; ey = 15 + k / 5; ec = 0; end
      else begin ex = (k - 25) % 5; ey = (k - 25) / 5; ec = 6; end
      checks++;
      if (px_x[k] !== ex || px_y[k] !== ey || px_c[k] !== ec) begin
        errors++;
        $display("FAIL erase_pixel[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 k, px_x[k], px_y[k], px_c[k], ex, ey, ec);
      end
    end
  endtask

  task automatic test_checkerboard();
    int cyc, j, n_exp;
    logic [24:0] shp;
    logic b;
    shp = 25'h1555555;
    go5(5'd1, 4'd1, shp, 3'b011, cyc);
    checks++;
    if (cyc !== 52) begin errors++; $display("FAIL checker_latency: got %0d want 52", cyc); end
    for (int k = 0; k < 25 && k < px_x.size(); k++) begin
      checks++;
      if (px_x[k] !== k % 5 || px_y[k] !== k / 5 || px_c[k] !== 0) begin
        errors++;
        $display("FAIL checker_erase[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,0)",
                 k, px_x[k], px_y[k], px_c[k], k % 5, k / 5);
      end
    end
    j = 25;
    n_exp = 0;
    for (int k = 0; k < 25; k++) begin
      b = shp[24 - k];
`ifdef SPRITE_TRANSPARENT_EN
      if (!b) continue;
`endif
      n_exp++;
      if (j < px_x.size()) begin
        checks++;
        if (px_x[j] !== 5 + k % 5 || px_y[j] !== 5 + k / 5 || px_c[j] !== (b ? 3 : 0)) begin
          errors++;
          $display("FAIL checker_draw[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   k, px_x[j], px_y[j], px_c[j], 5 + k % 5, 5 + k / 5, b ? 3 : 0);
        end
      end
      j++;
    end
    checks++;
    if (px_x.size() !== 25 + n_exp) begin
      errors++; $display("FAIL checker_count: got %0d want %0d", px_x.size(), 25 + n_exp);
    end
  endtask

  task automatic test_start_ignored();
    px_x.delete(); px_y.delete(); px_c.delete();
    done_cnt = 0;
    tile_x = 5'd2; tile_y = 4'd2; shape = 25'h1FFFFFF; colour = 3'b001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignored_busy: got %b want 1", busy); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL ignored_done_cnt: got %0d want 1", done_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignored_idle: got busy=%b want 0", busy); end
    checks++;
    if (px_x.size() !== 50) begin errors++; $display("FAIL ignored_plots: got %0d want 50", px_x.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    done_cnt = 0;
    tile_x = 5'd0; tile_y = 4'd3; shape = 25'h1FFFFFF; colour = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin @(posedge clk); cyc++; #1; end
    checks++;
    if (cyc !== 52) begin errors++; $display("FAIL b2b_first_latency: got %0d want 52", cyc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: got busy=%b done=%b want 1/0", busy, done);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin @(posedge clk); cyc++; #1; end
    start = 1'b0;
    checks++;
    if (cyc !== 52) begin errors++; $display("FAIL b2b_second_latency: got %0d want 52", cyc); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: got done_cnt=%0d busy=%b want 2/0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_erase();
    int cyc, n;
    tile_x = 5'd1; tile_y = 4'd0; shape = 25'h1FFFFFF; colour = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || plot !== 1'b1 || col_out !== 3'd0) begin
      errors++; $display("FAIL mid_erase_active: got busy=%b plot=%b c=%0d want 1/1/0", busy, plot, col_out);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, plot, x_out, y_out, col_out} !== 21'd0) begin
      errors++; $display("FAIL async_reset: got busy=%b plot=%b x=%0d y=%0d c=%0d want 0",
                         busy, plot, x_out, y_out, col_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    go5(5'd3, 4'd2, 25'h1FFFFFF, 3'b101, cyc);
    n = px_x.size();
    checks++;
    if (cyc !== 27 || n !== 25) begin
      errors++; $display("FAIL post_reset_no_erase: got latency=%0d plots=%0d want 27/25", cyc, n);
    end
    if (n == 25) begin
      checks++;
      if (px_x[0] !== 15 || px_y[0] !== 10 || px_c[0] !== 5 || px_x[24] !== 19 || px_y[24] !== 14) begin
        errors++; $display("FAIL post_reset_pixels: got first (%0d,%0d,%0d) last (%0d,%0d) want (15,10,5) (19,14)",
                           px_x[0], px_y[0], px_c[0], px_x[24], px_y[24]);
      end
    end
  endtask

  task automatic test_wide_wrap();
    int k, cyc;
    logic [7:0] ex;
    logic [6:0] ey;
    tile_x8 = 5'd31; tile_y8 = 4'd0; shape8 = '1; colour8 = 3'b111; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    k = 0; cyc = 0;
    while (done8 !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (plot8) begin
        ex = 8'(248 + k % 8);
        ey = 7'(k / 8);
        checks++;
        if (x8 !== ex || y8 !== ey) begin
          errors++; $display("FAIL w8_pixel[%0d]: got (%0d,%0d) want (%0d,%0d)", k, x8, y8, ex, ey);
        end
        k++;
      end
    end
    checks++;
    if (k !== 48) begin errors++; $display("FAIL w8_count: got %0d want 48", k); end

    @(posedge clk); #1;
    tile_x9 = 5'd31; tile_y9 = 4'd0; shape9 = '1; colour9 = 3'b100; start9 = 1'b1;
    @(posedge clk); #1;
    start9 = 1'b0;
    k = 0; cyc = 0;
    while (done9 !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (plot9) begin
        ex = 8'(23 + k % 9);
        ey = 7'(k / 9);
        checks++;
        if (x9 !== ex || y9 !== ey || col9 !== 3'b100) begin
          errors++; $display("FAIL w9_pixel[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,4)", k, x9, y9, col9, ex, ey);
        end
        k++;
      end
    end
    checks++;
    if (k !== 54) begin errors++; $display("FAIL w9_count: got %0d want 54", k); end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; tile_x = '0; tile_y = '0; shape = '0; colour = '0;
    start8 = 1'b0; tile_x8 = '0; tile_y8 = '0; shape8 = '0; colour8 = '0;
    start9 = 1'b0; tile_x9 = '0; tile_y9 = '0; shape9 = '0; colour9 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_first_draw();
    test_redraw_erase();
    test_checkerboard();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_erase();
    test_wide_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
